// File: rtl/cache_req_frontend.sv
// Trace-command front end for the LLC: legality check, address split,
// small request FIFO and saturating accept/illegal statistics.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   trace command handshake (in_cmd, in_addr)
//   out_valid/out_ready decoded request handshake
//   out_cmd/out_tag/out_index/out_offset  head-of-FIFO fields
//   accept_cnt          legal commands enqueued (saturating)
//   illegal_cnt         illegal commands dropped (saturating)
module cache_req_frontend #(
  parameter int ADDR_W   = 32,
  parameter int TAG_W    = 12,
  parameter int INDEX_W  = 14,
  parameter int OFFSET_W = 6,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_cmd,
  input  logic [ADDR_W-1:0]   in_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_cmd,
  output logic [TAG_W-1:0]    out_tag,
  output logic [INDEX_W-1:0]  out_index,
  output logic [OFFSET_W-1:0] out_offset,
  output logic [CNT_W-1:0]    accept_cnt,
  output logic [CNT_W-1:0]    illegal_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = $clog2(DEPTH + 1);

  if (TAG_W + INDEX_W + OFFSET_W != ADDR_W) begin : g_bad_split
    $fatal(1, "TAG_W+INDEX_W+OFFSET_W must equal ADDR_W");
  end

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "DEPTH must be a power of two >= 2");
  end

  logic [3:0]          r_cmd [DEPTH];
  logic [TAG_W-1:0]    r_tag [DEPTH];
  logic [INDEX_W-1:0]  r_idx [DEPTH];
  logic [OFFSET_W-1:0] r_off [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_FW-1:0] r_count;
  logic [CNT_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_ill;

  logic w_full;
  logic w_empty;
  logic w_legal;
  logic w_xfer;
  logic w_push;
  logic w_ill;
  logic w_pop;

  always_comb begin
    w_legal = 1'b0;
    case (in_cmd)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd8, 4'd9: w_legal = 1'b1;
      default:                w_legal = 1'b0;
    endcase
  end

  assign w_full  = (r_count == CNT_FW'(DEPTH));
  assign w_empty = (r_count == '0);

  // ready depends on full only, so a same-cycle pop never frees a slot
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;

  assign w_xfer = in_valid && in_ready;
  assign w_push = w_xfer && w_legal;
  assign w_ill  = w_xfer && !w_legal;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cmd[i] <= '0;
        r_tag[i] <= '0;
        r_idx[i] <= '0;
        r_off[i] <= '0;
      end
    end else if (w_push) begin
      r_cmd[r_tail] <= in_cmd;
      r_tag[r_tail] <= in_addr[ADDR_W-1:INDEX_W+OFFSET_W];
      r_idx[r_tail] <= in_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
      r_off[r_tail] <= in_addr[OFFSET_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_FW'(1);
        2'b01:   r_count <= r_count - CNT_FW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ill <= '0;
    end else begin
      if (w_push && (r_acc != {CNT_W{1'b1}})) r_acc <= r_acc + CNT_W'(1);
      if (w_ill && (r_ill != {CNT_W{1'b1}}))  r_ill <= r_ill + CNT_W'(1);
    end
  end

  assign out_cmd     = r_cmd[r_head];
  assign out_tag     = r_tag[r_head];
  assign out_index   = r_idx[r_head];
  assign out_offset  = r_off[r_head];
  assign accept_cnt  = r_acc;
  assign illegal_cnt = r_ill;

endmodule

// File: tb/tb_cache_req_frontend.sv
// Directed bench for cache_req_frontend, plus a CNT_W=4 copy
// driven in lockstep to observe counter saturation.
module tb_cache_req_frontend;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_addr = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [3:0]  out_cmd;
  logic [11:0] out_tag;
  logic [13:0] out_index;
  logic [5:0]  out_offset;
  logic [15:0] accept_cnt, illegal_cnt;

  logic        s_in_ready, s_out_valid;
  logic [3:0]  s_out_cmd;
  logic [11:0] s_out_tag;
  logic [13:0] s_out_index;
  logic [5:0]  s_out_offset;
  logic [3:0]  s_acc, s_ill;

  int n_chk = 0;
  int n_pass = 0;
  int exp_acc = 0;

  always #5 clk = ~clk;

  cache_req_frontend dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cmd(out_cmd), .out_tag(out_tag),
    .out_index(out_index), .out_offset(out_offset),
    .accept_cnt(accept_cnt), .illegal_cnt(illegal_cnt)
  );

  cache_req_frontend #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_cmd(in_cmd), .in_addr(in_addr),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_cmd(s_out_cmd), .out_tag(s_out_tag),
    .out_index(s_out_index), .out_offset(s_out_offset),
    .accept_cnt(s_acc), .illegal_cnt(s_ill)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat15(input int v);
    return (v > 15) ? 32'd15 : 32'(v);
  endfunction

  logic [3:0]  cmds [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                            4'd5, 4'd6, 4'd8, 4'd9};
  logic [31:0] a2 [4] = '{32'hAAA0_0040, 32'h0010_0081,
                          32'hFFFF_FFFF, 32'h0000_0000};

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_acc", 32'(accept_cnt), 32'd0);
    chk("rst_ill", 32'(illegal_cnt), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    #6 rst_n = 1'b1;

    // single transfer and address split
    in_valid = 1'b1; in_cmd = 4'd0; in_addr = 32'h1234_5678;
    step();
    in_valid = 1'b0;
    exp_acc = 1;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_cmd", 32'(out_cmd), 32'd0);
    chk("t1_tag", 32'(out_tag), 32'h123);
    chk("t1_index", 32'(out_index), 32'h1159);
    chk("t1_offset", 32'(out_offset), 32'h38);
    chk("t1_acc", 32'(accept_cnt), 32'd1);
    step(); step();
    chk("t1_hold_valid", 32'(out_valid), 32'd1);
    chk("t1_hold_tag", 32'(out_tag), 32'h123);
    chk("t1_hold_index", 32'(out_index), 32'h1159);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_popped", 32'(out_valid), 32'd0);

    // fill to full, pop-while-full does not admit a push
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_cmd = 4'(i + 1); in_addr = a2[i];
      step();
    end
    exp_acc += 4;
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    chk("t2_head_cmd", 32'(out_cmd), 32'd1);
    in_cmd = 4'd5; in_addr = 32'h0BAD_F00D; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2_popfull_ready", 32'(in_ready), 32'd1);
    chk("t2_popfull_acc", 32'(accept_cnt), 32'(exp_acc));
    chk("t2_popfull_head", 32'(out_cmd), 32'd2);
    step();
    in_valid = 1'b0;
    exp_acc += 1;
    chk("t2_push_after", 32'(accept_cnt), 32'(exp_acc));
    chk("t2_full_again", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    chk("t2_o2_cmd", 32'(out_cmd), 32'd2);
    chk("t2_o2_tag", 32'(out_tag), 32'h001);
    chk("t2_o2_idx", 32'(out_index), 32'h0002);
    chk("t2_o2_off", 32'(out_offset), 32'h01);
    step();
    chk("t2_o3_cmd", 32'(out_cmd), 32'd3);
    chk("t2_o3_tag", 32'(out_tag), 32'hFFF);
    chk("t2_o3_idx", 32'(out_index), 32'h3FFF);
    chk("t2_o3_off", 32'(out_offset), 32'h3F);
    step();
    chk("t2_o4_cmd", 32'(out_cmd), 32'd4);
    chk("t2_o4_tag", 32'(out_tag), 32'h000);
    step();
    chk("t2_o5_cmd", 32'(out_cmd), 32'd5);
    chk("t2_o5_tag", 32'(out_tag), 32'h0BA);
    chk("t2_o5_idx", 32'(out_index), 32'h37C0);
    chk("t2_o5_off", 32'(out_offset), 32'h0D);
    step();
    out_ready = 1'b0;
    chk("t2_drained", 32'(out_valid), 32'd0);
    chk("t2_sat_acc", 32'(s_acc), sat15(exp_acc));

    // illegal opcodes dropped
    in_valid = 1'b1; in_cmd = 4'd7; in_addr = 32'h1;
    step();
    in_cmd = 4'd15;
    step();
    in_valid = 1'b0;
    chk("t3_valid", 32'(out_valid), 32'd0);
    chk("t3_ill", 32'(illegal_cnt), 32'd2);
    chk("t3_acc", 32'(accept_cnt), 32'(exp_acc));

    // streaming, one push and one pop per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_cmd = cmds[i % 9];
      in_addr = (32'(i) << 20) | (32'(i) << 6) | 32'(i);
      step();
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_ready", 32'(in_ready), 32'd1);
      chk("t4_cmd", 32'(out_cmd), 32'(cmds[i % 9]));
      chk("t4_tag", 32'(out_tag), 32'(i));
      chk("t4_idx", 32'(out_index), 32'(i));
      chk("t4_off", 32'(out_offset), 32'(i));
    end
    in_valid = 1'b0;
    exp_acc += 20;
    step();
    out_ready = 1'b0;
    chk("t4_empty", 32'(out_valid), 32'd0);
    chk("t4_acc", 32'(accept_cnt), 32'(exp_acc));
    chk("t5_sat_acc", 32'(s_acc), sat15(exp_acc));
    chk("t5_sat_ill", 32'(s_ill), 32'd2);

    // asynchronous reset with entries in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_cmd = 4'd1; in_addr = 32'hFFF0_0000;
      step();
    end
    in_valid = 1'b0;
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_acc", 32'(accept_cnt), 32'd0);
    chk("t6_rst_ill", 32'(illegal_cnt), 32'd0);
    chk("t6_rst_cmd", 32'(out_cmd), 32'd0);
    chk("t6_rst_tag", 32'(out_tag), 32'd0);
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_cmd = 4'd9; in_addr = 32'h0040_0080;
    step();
    in_valid = 1'b0;
    chk("t6_new_valid", 32'(out_valid), 32'd1);
    chk("t6_new_cmd", 32'(out_cmd), 32'd9);
    chk("t6_new_idx", 32'(out_index), 32'h0002);
    chk("t6_new_acc", 32'(accept_cnt), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_no_stale", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_req_frontend.md
Name: cache_req_frontend

Overview:
- Upstream request stage of the 16 MB, 16-way, 64 B-line, MESI last-level cache.
- Accepts raw trace commands (4-bit opcode plus 32-bit address) over a valid/ready handshake. Rejects illegal opcodes.
- Splits each address into tag, set index and byte offset. Buffers legal requests in a small FIFO and presents them to the cache controller over a second valid/ready handshake.
- Keeps saturating counters of accepted and illegal commands.

Parameters:
- ADDR_W, 32, trace address width.
- TAG_W, 12, tag field width. Equals the cache tag width.
- INDEX_W, 14, set index width. 16384 sets.
- OFFSET_W, 6, byte-offset width. 64 B line.
- DEPTH, 4, FIFO entries. Power of two, at least 2.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  trace command present.
- in_ready  out  1  block can take a command this cycle.
- in_cmd  in  4  trace opcode.
- in_addr  in  ADDR_W  byte address.
- out_valid  out  1  decoded request available at FIFO head.
- out_ready  in  1  cache controller consumes the head.
- out_cmd  out  4  opcode of head entry.
- out_tag  out  TAG_W  head addr[ADDR_W-1 : INDEX_W+OFFSET_W].
- out_index  out  INDEX_W  head addr[INDEX_W+OFFSET_W-1 : OFFSET_W].
- out_offset  out  OFFSET_W  head addr[OFFSET_W-1:0].
- accept_cnt  out  CNT_W  legal commands enqueued.
- illegal_cnt  out  CNT_W  illegal commands dropped.

Behaviour:
- Elaboration check: TAG_W+INDEX_W+OFFSET_W must equal ADDR_W, otherwise a fatal error.
- Legal opcodes: 0 read, 1 write, 2 instruction fetch, 3 snooped read, 4 snooped write, 5 snooped RWIM, 6 snooped invalidate, 8 clear/reset, 9 print. Opcodes 7 and 10-15 are illegal.
- Input handshake: a transfer occurs when in_valid && in_ready.
  - in_ready = !full. A pop in the same cycle does NOT free the slot for a push when full; this is deliberate, for deterministic timing.
- Legal transfer: decoded fields are written into the FIFO at the tail; tail and count advance.
- Illegal transfer: consumed and not enqueued; illegal_cnt increments.
  - An illegal command arriving while full waits (in_ready=0) like any other.
- Output handshake: out_valid = !empty.
  - out_* fields are read combinationally from the head entry.
  - On out_valid && out_ready, head and count advance.
  - Fields must hold stable while out_valid=1 and out_ready=0.
- Latency: a command accepted in cycle N is visible on out_valid in cycle N+1 when the FIFO was empty. No combinational in-to-out path.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH; full = (count==DEPTH), empty = (count==0).
- Counters:
  - accept_cnt increments once per legal transfer; illegal_cnt once per illegal transfer.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Opcode 8 does NOT clear them here. It is only forwarded; the stats owner clears downstream.
- Reset (asynchronous, any time including mid-transfer):
  - pointers=0, count=0, out_valid=0, in_ready=1 (combinational from count), accept_cnt=0, illegal_cnt=0.
  - out_cmd/out_tag/out_index/out_offset read 0: FIFO storage cleared on reset.
  - In-flight entries are discarded.
  - First acceptance is possible on the first clk edge after rst_n deasserts.

Test Plan:
- Reset, then one transfer cmd=0, addr=0x12345678, out_ready=0 -> next cycle out_valid=1, out_tag=0x123, out_index=0x1159, out_offset=0x38, accept_cnt=1. Fields stable until out_ready=1.
- Push 4 legal commands with out_ready=0 -> in_ready=0 after the 4th. Assert in_valid with out_ready=1 on the same cycle -> only the pop occurs. Push succeeds the following cycle. Output order is FIFO.
- Send cmd=7 and then cmd=15 -> neither appears on out_valid; illegal_cnt=2, accept_cnt unchanged.
- Continuous streaming of 20 commands (cmd 0..6,8,9 cycling) with out_ready=1 and the FIFO never full -> one push and one pop per cycle, count stable at 1, output order matches input.
- With CNT_W=4, send 20 legal commands -> accept_cnt saturates at 15.
- Fill 3 entries, assert rst_n=0 between clock edges -> out_valid=0, counters=0, in_ready=1 immediately. After release, a new command emerges with no stale entry.
